// File: rtl/intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : intr_ctrl                                                       |
// | Brief    : Nesting priority interrupt controller. It has an edge-latched    |
// |            pending set, an enable mask and an in-service LIFO stack.        |
// |            Optional INTR_SYNC_EN adds a two-flop input synchronizer.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module intr_ctrl #(
  parameter int unsigned N_SRC      = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = 'h010,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         irq_in,
  input  logic                     mask_we,
  input  logic [N_SRC-1:0]         mask_din,
  output logic [N_SRC-1:0]         mask_q,
  output logic                     int_req,
  output logic [$clog2(N_SRC)-1:0] int_id,
  output logic [ADDR_W-1:0]        int_vec,
  input  logic                     int_ack,
  input  logic                     int_ret,
  output logic [N_SRC-1:0]         pending_q,
  output logic [3:0]               nest_level,
  output logic                     err
);

  localparam int unsigned c_ID_W   = $clog2(N_SRC);
  localparam int unsigned c_PTR_W  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int unsigned c_STK_SZ = 1 << c_PTR_W;
  localparam logic [3:0]  c_DEPTH  = 4'(NEST_DEPTH);

  logic [N_SRC-1:0]  w_irq;
  logic [N_SRC-1:0]  r_irq_prev;
  logic [N_SRC-1:0]  r_pending;
  logic [N_SRC-1:0]  r_mask;
  logic [c_ID_W-1:0] r_stack [c_STK_SZ];
  logic [3:0]        r_level;
  logic              r_err;

  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_ack_clr;
  logic [c_ID_W-1:0]  w_cand;
  logic               w_cand_vld;
  logic [c_ID_W-1:0]  w_top;
  logic [c_PTR_W-1:0] w_top_ptr;
  logic [c_PTR_W-1:0] w_push_ptr;
  logic               w_eligible;

`ifdef INTR_SYNC_EN
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = irq_in;
`endif

  assign w_edge = w_irq & ~r_irq_prev;

  // Lowest index wins, so scan downwards and let later hits override.
  always_comb begin
    w_cand     = '0;
    w_cand_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r_pending[i] && r_mask[i]) begin
        w_cand     = c_ID_W'(i);
        w_cand_vld = 1'b1;
      end
    end
  end

  assign w_top_ptr  = c_PTR_W'(r_level - 4'd1);
  assign w_push_ptr = r_level[c_PTR_W-1:0];
  assign w_top      = r_stack[w_top_ptr];
  assign w_eligible = w_cand_vld && (r_level != c_DEPTH) &&
                      ((r_level == 4'd0) || (w_cand < w_top));

  assign int_req    = w_eligible;
  assign int_id     = w_eligible ? w_cand : '0;
  assign int_vec    = ADDR_W'(VEC_BASE) + ADDR_W'(VEC_STRIDE) * ADDR_W'(int_id);
  assign w_ack_clr  = (int_ack && int_req) ? (N_SRC'(1) << int_id) : '0;

  assign mask_q     = r_mask;
  assign pending_q  = r_pending;
  assign nest_level = r_level;
  assign err        = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '1;
      r_level    <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < c_STK_SZ; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_irq_prev <= w_irq;
      // A fresh edge in the ack cycle outranks the clear.
      r_pending  <= (r_pending & ~w_ack_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_din;
      end
      if (int_ack) begin
        if (int_req) begin
          r_stack[w_push_ptr] <= int_id;
          r_level             <= r_level + 4'd1;
        end else begin
          r_err <= 1'b1;
        end
        if (int_ret) begin
          r_err <= 1'b1;
        end
      end else if (int_ret) begin
        if (r_level == 4'd0) begin
          r_err <= 1'b1;
        end else begin
          r_level <= r_level - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
